rayid_alloc_ctrl: RTL
=====================

Name: rayid_alloc_ctrl

Overview:
Free-list controller that owns the shader's pool of rayIDs. After reset it seeds the pool with every ID in sequence, then hands IDs to the primary ray generator through a valid/stall handshake. It reclaims IDs from several return paths (shader retire, shadow miss, and so on) using round-robin arbitration, with one free accepted per cycle. It sits between the ray generator, the shader's retire paths and the raystore/ray_data BRAM address space.

Parameters:
NUM_IDS, 512, size of the rayID pool; power of two.
ID_W, 9, rayID width; equals log2(NUM_IDS).
NUM_RET, 4, number of free/return requesters.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
alloc_valid  out  1  an ID is offered on alloc_id
alloc_id  out  ID_W  ID at the head of the free list
alloc_stall  in  1  consumer not accepting this cycle
free_valid  in  NUM_RET  per-requester free request
free_id  in  NUM_RET*ID_W  packed IDs being returned; requester i occupies bits [i*ID_W +: ID_W]
free_stall  out  NUM_RET  per-requester stall
init_done  out  1  pool seeded, controller in RUN
num_free  out  ID_W+1  IDs currently in the free list
err_double_free  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Storage: internal NUM_IDS x ID_W array used as a circular FIFO.
  - Pointers: head rd_ptr and tail wr_ptr, both ID_W bits, wrapping modulo NUM_IDS.
  - Count register: ID_W+1 bits.
  - Reads are first-word fall-through: alloc_id = mem[rd_ptr] combinationally.
- State machine:
  - INIT: entered on rst.
    - Each cycle: write init_cnt to mem[wr_ptr], then increment wr_ptr, init_cnt and count.
    - After writing NUM_IDS-1, go to RUN. INIT lasts exactly NUM_IDS cycles after rst deasserts.
  - RUN: normal operation; exits only on rst.
- Reset values:
  - State = INIT; rd_ptr, wr_ptr, init_cnt and count = 0.
  - alloc_valid = 0, init_done = 0, num_free = 0, err_double_free = 0.
  - free_stall = all ones.
- INIT:
  - alloc_valid = 0.
  - free_stall = all ones.
  - num_free tracks the seeding count.
- RUN, allocate side:
  - alloc_valid = (count != 0).
  - Pop occurs when alloc_valid & ~alloc_stall: rd_ptr+1, count-1.
  - alloc_id and alloc_valid are held stable while stalled.
- RUN, free arbitration:
  - Round-robin with priority pointer rr (log2 NUM_IDS-independent, clog2(NUM_RET) bits), reset 0.
  - grant = first i in order rr, rr+1, ... (mod NUM_RET) with free_valid[i].
  - free_stall[grant] = 0; all other bits = 1.
  - If no request, or count == NUM_IDS, then free_stall = all ones and nothing is accepted.
  - On acceptance: mem[wr_ptr] <= free_id[grant], wr_ptr+1, count+1, rr <= grant+1.
  - rr does not change when nothing is accepted.
- Simultaneous pop and push in one cycle: both pointers advance and count is unchanged.
- Empty plus free in the same cycle: no bypass. alloc_valid stays 0 that cycle; the freed ID is offered the next cycle.
- count is never decremented below 0 and never incremented above NUM_IDS.
- num_free = count, registered; it reflects state after the last clock edge.
- Wrap-around: pointers roll from NUM_IDS-1 to 0 with no bubble.
- rst asserted mid-RUN: all outstanding IDs are forgotten and the pool is reseeded from INIT. Callers must flush in-flight rays alongside.
- ID order: first NUM_IDS allocations after reset yield 0, 1, ..., NUM_IDS-1. After that, order follows free order (FIFO).

Optional Feature:
Macro RAYID_DOUBLE_FREE_CHK_EN.
- Defined:
  - Keeps a NUM_IDS-bit in_use vector; bit set on pop, cleared on accepted free.
  - A granted free whose ID has in_use == 0 is still handshaken (free_stall = 0, rr advances) but is not pushed.
  - In that case count and wr_ptr are unchanged and err_double_free is set; it stays set until rst.
  - in_use resets to all zeros.
- Not defined:
  - No in_use storage; every granted free is pushed.
  - err_double_free is tied to 0.

Test Plan:
1. Release rst, hold alloc_stall=0 -> init_done rises exactly 512 cycles after rst falls; num_free=512; alloc_id sequence 0,1,2,... one per cycle; alloc_valid drops after 512 pops, with num_free=0.
2. Pool empty, free_valid=4'b0001 with free_id[0]=9'h07 -> same cycle alloc_valid=0; next cycle alloc_valid=1, alloc_id=9'h07, num_free=1.
3. RUN, rr=0, free_valid=4'b1111 held 4 cycles with IDs 10,11,12,13 -> grants on ports 0,1,2,3 in order; free_stall patterns 1110,1101,1011,0111; num_free +4.
4. num_free=5, pop and free accepted in the same cycle -> num_free stays 5; freed ID appears after the 5 older entries.
5. Assert rst for 1 cycle mid-RUN with num_free=37 -> next cycle init_done=0, alloc_valid=0, free_stall=4'b1111; reseed completes 512 cycles later with alloc_id=0.
6. With RAYID_DOUBLE_FREE_CHK_EN: free ID 3 twice after one allocation -> first free pushed; second free is handshaken, num_free unchanged, err_double_free=1 and held. Without the macro: both pushed, err_double_free=0.

Source files
------------

// File: rtl/rayid_alloc_ctrl.sv
// rayID free-list controller: seeds the pool after reset, then serves allocations
// and round-robin arbitrated frees. Optional double-free check: RAYID_DOUBLE_FREE_CHK_EN.
module rayid_alloc_ctrl #(
  parameter int NUM_IDS = 512,
  parameter int ID_W    = 9,
  parameter int NUM_RET = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    alloc_valid,
  output logic [ID_W-1:0]         alloc_id,
  input  logic                    alloc_stall,
  input  logic [NUM_RET-1:0]      free_valid,
  input  logic [NUM_RET*ID_W-1:0] free_id,
  output logic [NUM_RET-1:0]      free_stall,
  output logic                    init_done,
  output logic [ID_W:0]           num_free,
  output logic                    err_double_free
);

  // state  | meaning
  // S_INIT | seeding the pool with IDs 0..NUM_IDS-1, one per cycle
  // S_RUN  | serving allocations and accepting frees

  localparam int              RR_W       = (NUM_RET > 1) ? $clog2(NUM_RET) : 1;
  localparam logic [ID_W:0]   COUNT_FULL = (ID_W+1)'(NUM_IDS);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_IDS - 1);
  localparam logic [RR_W-1:0] LAST_RET   = RR_W'(NUM_RET - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          state;
  logic [ID_W-1:0] mem [NUM_IDS];
  logic [ID_W-1:0] rd_ptr;
  logic [ID_W-1:0] wr_ptr;
  logic [ID_W-1:0] init_cnt;
  logic [ID_W:0]   count;
  logic [ID_W:0]   count_next;
  logic [RR_W-1:0] rr;

  logic            grant_any;
  logic [RR_W-1:0] grant_idx;
  logic [RR_W-1:0] cand;
  logic [ID_W-1:0] grant_id;
  logic            accept;
  logic            push;
  logic            pop;
  logic            mem_we;
  logic [ID_W-1:0] mem_wdata;

  // Scan requesters starting at the priority pointer, wrapping modulo NUM_RET.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (int'(rr) + k >= NUM_RET) cand = RR_W'(int'(rr) + k - NUM_RET);
      else                          cand = RR_W'(int'(rr) + k);
      if (!grant_any && free_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_id = '0;
    for (int k = 0; k < NUM_RET; k++) begin
      if (grant_idx == RR_W'(k)) grant_id = free_id[k*ID_W +: ID_W];
    end
  end

  assign accept = (state == S_RUN) && grant_any && (count != COUNT_FULL);
  assign pop    = (state == S_RUN) && alloc_valid && !alloc_stall;

  always_comb begin
    for (int k = 0; k < NUM_RET; k++) begin
      free_stall[k] = !(accept && (grant_idx == RR_W'(k)));
    end
  end

`ifdef RAYID_DOUBLE_FREE_CHK_EN
  logic [NUM_IDS-1:0] in_use;

  // A free of an ID not currently allocated is acknowledged but dropped.
  assign push = accept && in_use[grant_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      in_use          <= '0;
      err_double_free <= 1'b0;
    end else if (state == S_RUN) begin
      if (accept) begin
        if (in_use[grant_id]) in_use[grant_id] <= 1'b0;
        else                  err_double_free  <= 1'b1;
      end
      if (pop) in_use[alloc_id] <= 1'b1;
    end
  end
`else
  assign push            = accept;
  assign err_double_free = 1'b0;
`endif

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  assign mem_we    = !rst && ((state == S_INIT) || push);
  assign mem_wdata = (state == S_INIT) ? init_cnt : grant_id;

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= mem_wdata;
  end

  assign alloc_id = mem[rd_ptr];
  assign num_free = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      init_cnt    <= '0;
      count       <= '0;
      rr          <= '0;
      alloc_valid <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          wr_ptr   <= wr_ptr + 1'b1;
          init_cnt <= init_cnt + 1'b1;
          count    <= count + 1'b1;
          if (init_cnt == LAST_ID) begin
            state       <= S_RUN;
            init_done   <= 1'b1;
            alloc_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (accept) rr <= (grant_idx == LAST_RET) ? '0 : grant_idx + 1'b1;
          count       <= count_next;
          alloc_valid <= (count_next != '0);
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
